pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage Thumb pipeline (IF, ID, EX, MEM, WB).
- Per cycle, compares register tags across stages and drives stall, bubble and flush controls to the pipeline registers.
- Drives operand forwarding selects for EX.
- Freezes the whole pipe while data memory has not acknowledged a request.
- Keeps saturating stall and flush counters for performance debug.

Parameters:
REG_W, 3, register index width (r0-r7, Thumb low registers; r0 is a normal register and may be forwarded)
FLUSH_CYCLES, 2, cycles the front end is flushed after a taken branch resolves in EX (1..15)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
id_rs1 / id_rs2  in  REG_W each  source registers of the instruction in ID
id_rs1_used / id_rs2_used  in  1 each  ID instruction reads that source
id_valid  in  1  ID holds a real instruction
ex_rs1 / ex_rs2  in  REG_W each  source registers of the instruction in EX
ex_rs1_used / ex_rs2_used  in  1 each  EX instruction reads that source
ex_valid, ex_wr_en, ex_is_load  in  1 each  EX instruction: valid, writes rd, is a load
ex_rd  in  REG_W  EX destination
ex_branch_taken  in  1  branch in EX resolved taken (qualified by ex_valid)
mem_valid, mem_wr_en  in  1 each  MEM instruction: valid, writes rd
mem_rd  in  REG_W  MEM destination
wb_valid, wb_wr_en  in  1 each  WB instruction: valid, writes rd
wb_rd  in  REG_W  WB destination
dmem_req, dmem_ack  in  1 each  data memory request pending / completed this cycle
pc_stall, if_id_stall  out  1 each  hold PC / hold IF/ID register
id_ex_bubble  out  1  load ID/EX with a NOP
if_id_flush  out  1  load IF/ID with a NOP
freeze  out  1  hold every pipeline register including EX/MEM and MEM/WB
fwd_a, fwd_b  out  2 each  EX operand source: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
stall_count, flush_count  out  CNT_W each  saturating cycle counters

Behaviour:
- State register holds RUN, LOAD_STALL or FLUSH, plus flush_left[3:0].
- Control outputs are combinational from the registered state and the current inputs. The counters are registered.
- Reset (rst=1 at an edge): state RUN, flush_left 0, both counters 0. While rst is high, all 1-bit outputs are 0 and fwd_a/fwd_b are 00.
- mem_wait is defined as dmem_req & ~dmem_ack.
- Priority each cycle: mem_wait > branch > load-use > none.
- mem_wait: freeze=pc_stall=if_id_stall=1, bubble=0, flush=0. State, flush_left and all tags hold. stall_count increments.
- Branch (ex_valid & ex_branch_taken & ~mem_wait):
  - if_id_flush=1 and id_ex_bubble=1 this cycle.
  - Next state is FLUSH with flush_left=FLUSH_CYCLES-1, or RUN if FLUSH_CYCLES=1.
  - A simultaneous load-use is ignored, because its consumer is squashed.
  - flush_count increments.
- FLUSH state (~mem_wait): if_id_flush=1. flush_left decrements each cycle; leave to RUN when it is 0. flush_count increments per flushed cycle. Load-use detection is masked in this state.
- Load-use hazard: ex_valid & ex_is_load & ex_wr_en & id_valid & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - Response: pc_stall=if_id_stall=1 and id_ex_bubble=1 for exactly one cycle.
  - State goes to LOAD_STALL, then returns to RUN the next non-frozen cycle. This is a one-cycle penalty.
  - In LOAD_STALL the condition must not re-fire, since the load is then in MEM.
  - stall_count increments.
- Forwarding, evaluated per operand independently (shown for fwd_a):
  - 01 if mem_valid & mem_wr_en & ex_rs1_used & mem_rd==ex_rs1.
  - else 10 if wb_valid & wb_wr_en & ex_rs1_used & wb_rd==ex_rs1.
  - else 00.
  - MEM wins over WB when both match (youngest producer).
  - Forwarding stays active during freeze.
- Counters saturate at all-ones and do not wrap.
- Reset mid-FLUSH or mid-LOAD_STALL aborts the sequence. The next cycle is RUN with no residual flush.

Test Plan:
- ex: LDR r3 (ex_is_load=1, ex_rd=3); id: ADD reading r3 (id_rs1=3, used) -> cycle 1: pc_stall=if_id_stall=id_ex_bubble=1; cycle 2: all 0, stall_count=1.
- ex_branch_taken=1, FLUSH_CYCLES=2, with a simultaneous load-use match -> cycle 1: if_id_flush=id_ex_bubble=1, pc_stall=0; cycle 2: if_id_flush=1; cycle 3: RUN, flush_count=2, stall_count=0.
- mem_rd=5 & wb_rd=5 both writing, ex_rs1=5, ex_rs2=5, both used -> fwd_a=fwd_b=01; drop mem_wr_en -> both 10; ex_rs2_used=0 -> fwd_b=00.
- dmem_req=1, dmem_ack=0 for 3 cycles during FLUSH (flush_left=1) -> freeze=1 for 3 cycles, flush_left stays 1; after ack, 1 more flush cycle, then RUN; stall_count=3.
- CNT_W=4, hold mem_wait 20 cycles -> stall_count stops at 15.
- rst asserted in cycle 2 of FLUSH -> all outputs 0 in the reset cycle; after release, if_id_flush=0 and counters are 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline tags in,
// stall/flush/forward controls and counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic             id_valid;
  logic [REG_W-1:0] ex_rs1;
  logic [REG_W-1:0] ex_rs2;
  logic             ex_rs1_used;
  logic             ex_rs2_used;
  logic             ex_valid;
  logic             ex_wr_en;
  logic             ex_is_load;
  logic [REG_W-1:0] ex_rd;
  logic             ex_branch_taken;
  logic             mem_valid;
  logic             mem_wr_en;
  logic [REG_W-1:0] mem_rd;
  logic             wb_valid;
  logic             wb_wr_en;
  logic [REG_W-1:0] wb_rd;
  logic             dmem_req;
  logic             dmem_ack;
  logic             pc_stall;
  logic             if_id_stall;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             freeze;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_valid,
    output ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used,
    output ex_valid, ex_wr_en, ex_is_load, ex_rd, ex_branch_taken,
    output mem_valid, mem_wr_en, mem_rd,
    output wb_valid, wb_wr_en, wb_rd,
    output dmem_req, dmem_ack,
    input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, freeze,
    input  fwd_a, fwd_b, stall_count, flush_count
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_valid,
    input  ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used,
    input  ex_valid, ex_wr_en, ex_is_load, ex_rd, ex_branch_taken,
    input  mem_valid, mem_wr_en, mem_rd,
    input  wb_valid, wb_wr_en, wb_rd,
    input  dmem_req, dmem_ack,
    output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, freeze,
    output fwd_a, fwd_b, stall_count, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage Thumb pipeline hazard controller:
// load-use stall, branch flush, dmem freeze, forwarding.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input logic clk,
  input logic rst,
  pipeline_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    FLUSH
  } state_t;

  localparam logic [3:0] FL_INIT = 4'(FLUSH_CYCLES - 1);

  state_t     state;
  state_t     state_nx;
  logic [3:0] flush_left;
  logic [3:0] flush_left_nx;

  logic mem_wait;
  logic branch;
  logic lu_raw;
  logic lu;
  logic flushing;
  logic stall_ev;
  logic flush_ev;

  logic [1:0] fa;
  logic [1:0] fb;

  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  // Classify this cycle's event by priority
  always_comb begin
    mem_wait = bus.dmem_req & ~bus.dmem_ack;
    branch   = bus.ex_valid & bus.ex_branch_taken
             & ~mem_wait;
    lu_raw   = bus.ex_valid & bus.ex_is_load
             & bus.ex_wr_en & bus.id_valid
             & ((bus.id_rs1_used
                 & (bus.id_rs1 == bus.ex_rd))
              | (bus.id_rs2_used
                 & (bus.id_rs2 == bus.ex_rd)));
    // load stays masked in LOAD_STALL/FLUSH
    lu       = lu_raw & (state == RUN)
             & ~mem_wait & ~branch;
    flushing = (state == FLUSH) & ~mem_wait
             & ~branch;
    stall_ev = mem_wait | lu;
    flush_ev = branch | flushing;
  end

  // Operand A/B source select, MEM beats WB
  always_comb begin
    fa = 2'b00;
    if (bus.mem_valid & bus.mem_wr_en
        & bus.ex_rs1_used
        & (bus.mem_rd == bus.ex_rs1))
      fa = 2'b01;
    else if (bus.wb_valid & bus.wb_wr_en
             & bus.ex_rs1_used
             & (bus.wb_rd == bus.ex_rs1))
      fa = 2'b10;
    fb = 2'b00;
    if (bus.mem_valid & bus.mem_wr_en
        & bus.ex_rs2_used
        & (bus.mem_rd == bus.ex_rs2))
      fb = 2'b01;
    else if (bus.wb_valid & bus.wb_wr_en
             & bus.ex_rs2_used
             & (bus.wb_rd == bus.ex_rs2))
      fb = 2'b10;
  end

  // Controls are quiet while reset is held
  always_comb begin
    bus.freeze       = ~rst & mem_wait;
    bus.pc_stall     = ~rst & stall_ev;
    bus.if_id_stall  = ~rst & stall_ev;
    bus.id_ex_bubble = ~rst & (branch | lu);
    bus.if_id_flush  = ~rst & flush_ev;
    bus.fwd_a        = rst ? 2'b00 : fa;
    bus.fwd_b        = rst ? 2'b00 : fb;
    bus.stall_count  = stall_q;
    bus.flush_count  = flush_q;
  end

  // Next state; a frozen pipe holds everything
  always_comb begin
    state_nx      = state;
    flush_left_nx = flush_left;
    if (!mem_wait) begin
      if (branch) begin
        if (FLUSH_CYCLES > 1) begin
          state_nx      = FLUSH;
          flush_left_nx = FL_INIT;
        end else begin
          state_nx      = RUN;
          flush_left_nx = 4'd0;
        end
      end else begin
        unique case (state)
          RUN: begin
            if (lu)
              state_nx = LOAD_STALL;
          end
          LOAD_STALL: begin
            state_nx = RUN;
          end
          FLUSH: begin
            if (flush_left <= 4'd1) begin
              state_nx      = RUN;
              flush_left_nx = 4'd0;
            end else begin
              flush_left_nx = flush_left - 4'd1;
            end
          end
          default: begin
            state_nx      = RUN;
            flush_left_nx = 4'd0;
          end
        endcase
      end
    end
  end

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      flush_left <= 4'd0;
    end else begin
      state      <= state_nx;
      flush_left <= flush_left_nx;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_ev && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if (flush_ev && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: two
// instances (16-bit and 4-bit counters) share stimulus.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if #(.REG_W(3), .CNT_W(16)) a ();
  pipeline_hazard_ctrl_if #(.REG_W(3), .CNT_W(4))  b ();

  pipeline_hazard_ctrl #(
    .REG_W(3), .FLUSH_CYCLES(2), .CNT_W(16)
  ) dut (.clk(clk), .rst(rst), .bus(a.slave));

  pipeline_hazard_ctrl #(
    .REG_W(3), .FLUSH_CYCLES(2), .CNT_W(4)
  ) dut4 (.clk(clk), .rst(rst), .bus(b.slave));

  assign b.id_rs1          = a.id_rs1;
  assign b.id_rs2          = a.id_rs2;
  assign b.id_rs1_used     = a.id_rs1_used;
  assign b.id_rs2_used     = a.id_rs2_used;
  assign b.id_valid        = a.id_valid;
  assign b.ex_rs1          = a.ex_rs1;
  assign b.ex_rs2          = a.ex_rs2;
  assign b.ex_rs1_used     = a.ex_rs1_used;
  assign b.ex_rs2_used     = a.ex_rs2_used;
  assign b.ex_valid        = a.ex_valid;
  assign b.ex_wr_en        = a.ex_wr_en;
  assign b.ex_is_load      = a.ex_is_load;
  assign b.ex_rd           = a.ex_rd;
  assign b.ex_branch_taken = a.ex_branch_taken;
  assign b.mem_valid       = a.mem_valid;
  assign b.mem_wr_en       = a.mem_wr_en;
  assign b.mem_rd          = a.mem_rd;
  assign b.wb_valid        = a.wb_valid;
  assign b.wb_wr_en        = a.wb_wr_en;
  assign b.wb_rd           = a.wb_rd;
  assign b.dmem_req        = a.dmem_req;
  assign b.dmem_ack        = a.dmem_ack;

  typedef struct packed {
    logic        pc;
    logic        ifid;
    logic        bub;
    logic        fl;
    logic        frz;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] sc;
    logic [15:0] fc;
    logic [3:0]  sc4;
    logic [3:0]  fc4;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    t_stall = 0;
  int    t_flush = 0;

  function automatic int sat(int v, int mx);
    return (v > mx) ? mx : v;
  endfunction

  // Monitor: one expected entry per cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  g;
      string nm;
      e = exp_q.pop_front();
      nm = name_q.pop_front();
      g.pc   = a.pc_stall;
      g.ifid = a.if_id_stall;
      g.bub  = a.id_ex_bubble;
      g.fl   = a.if_id_flush;
      g.frz  = a.freeze;
      g.fa   = a.fwd_a;
      g.fb   = a.fwd_b;
      g.sc   = a.stall_count;
      g.fc   = a.flush_count;
      g.sc4  = b.stall_count;
      g.fc4  = b.flush_count;
      n_cmp++;
      if (g !== e || b.if_id_flush !== e.fl
          || b.pc_stall !== e.pc) begin
        n_bad++;
        $display("FAIL %s: got %h required %h", nm, g, e);
      end
    end
  end

  task automatic idle();
    a.id_rs1 = 0; a.id_rs2 = 0;
    a.id_rs1_used = 0; a.id_rs2_used = 0;
    a.id_valid = 0;
    a.ex_rs1 = 0; a.ex_rs2 = 0;
    a.ex_rs1_used = 0; a.ex_rs2_used = 0;
    a.ex_valid = 0; a.ex_wr_en = 0;
    a.ex_is_load = 0; a.ex_rd = 0;
    a.ex_branch_taken = 0;
    a.mem_valid = 0; a.mem_wr_en = 0; a.mem_rd = 0;
    a.wb_valid = 0; a.wb_wr_en = 0; a.wb_rd = 0;
    a.dmem_req = 0; a.dmem_ack = 0;
  endtask

  task automatic load_use(input logic [2:0] rd,
                          input logic [2:0] r1,
                          input logic [2:0] r2);
    a.ex_valid = 1; a.ex_is_load = 1;
    a.ex_wr_en = 1; a.ex_rd = rd;
    a.id_valid = 1;
    a.id_rs1 = r1; a.id_rs1_used = 1;
    a.id_rs2 = r2; a.id_rs2_used = 1;
  endtask

  // Push expected response, then advance one cycle
  task automatic step(input string nm,
                      input logic pc, input logic ifid,
                      input logic bub, input logic fl,
                      input logic frz,
                      input logic [1:0] fa,
                      input logic [1:0] fb);
    obs_t e;
    e.pc = pc; e.ifid = ifid; e.bub = bub;
    e.fl = fl; e.frz = frz; e.fa = fa; e.fb = fb;
    e.sc  = 16'(sat(t_stall, 65535));
    e.fc  = 16'(sat(t_flush, 65535));
    e.sc4 = 4'(sat(t_stall, 15));
    e.fc4 = 4'(sat(t_flush, 15));
    exp_q.push_back(e);
    name_q.push_back(nm);
    if (rst) begin
      t_stall = 0;
      t_flush = 0;
    end else begin
      if (pc) t_stall++;
      if (fl) t_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1;
    idle();
    @(posedge clk);
    #1;
    step("reset", 0,0,0,0,0, 2'b00, 2'b00);
    rst = 0;

    // load-use on rs1, then masked in LOAD_STALL
    load_use(3'd3, 3'd3, 3'd6);
    step("lu_rs1", 1,1,1,0,0, 2'b00, 2'b00);
    step("lu_hold", 0,0,0,0,0, 2'b00, 2'b00);
    idle();
    step("lu_idle", 0,0,0,0,0, 2'b00, 2'b00);
    load_use(3'd4, 3'd1, 3'd4);
    step("lu_rs2", 1,1,1,0,0, 2'b00, 2'b00);
    idle();
    step("lu_rs2_back", 0,0,0,0,0, 2'b00, 2'b00);
    load_use(3'd4, 3'd4, 3'd4);
    a.ex_is_load = 0;
    step("no_load", 0,0,0,0,0, 2'b00, 2'b00);
    load_use(3'd4, 3'd4, 3'd4);
    a.ex_wr_en = 0;
    step("no_wr", 0,0,0,0,0, 2'b00, 2'b00);
    load_use(3'd4, 3'd4, 3'd4);
    a.id_rs1_used = 0; a.id_rs2_used = 0;
    step("unused", 0,0,0,0,0, 2'b00, 2'b00);

    // taken branch with simultaneous load-use
    idle();
    load_use(3'd2, 3'd2, 3'd0);
    a.ex_branch_taken = 1;
    step("br_lu", 0,0,1,1,0, 2'b00, 2'b00);
    a.ex_branch_taken = 0;
    step("br_flush2", 0,0,0,1,0, 2'b00, 2'b00);
    idle();
    step("br_run", 0,0,0,0,0, 2'b00, 2'b00);

    // forwarding selects
    a.mem_valid = 1; a.mem_wr_en = 1; a.mem_rd = 5;
    a.wb_valid = 1; a.wb_wr_en = 1; a.wb_rd = 5;
    a.ex_rs1 = 5; a.ex_rs2 = 5;
    a.ex_rs1_used = 1; a.ex_rs2_used = 1;
    step("fwd_mem", 0,0,0,0,0, 2'b01, 2'b01);
    a.mem_wr_en = 0;
    step("fwd_wb", 0,0,0,0,0, 2'b10, 2'b10);
    a.ex_rs2_used = 0;
    step("fwd_b_off", 0,0,0,0,0, 2'b10, 2'b00);
    a.mem_wr_en = 1; a.mem_rd = 0;
    a.ex_rs1 = 0; a.ex_rs2 = 5; a.ex_rs2_used = 1;
    step("fwd_r0", 0,0,0,0,0, 2'b01, 2'b10);
    a.wb_valid = 0; a.mem_valid = 0;
    step("fwd_none", 0,0,0,0,0, 2'b00, 2'b00);

    // mem_wait freezes a flush sequence
    idle();
    a.ex_valid = 1; a.ex_branch_taken = 1;
    step("fz_br", 0,0,1,1,0, 2'b00, 2'b00);
    idle();
    a.dmem_req = 1;
    a.mem_valid = 1; a.mem_wr_en = 1; a.mem_rd = 7;
    a.ex_rs1 = 7; a.ex_rs1_used = 1;
    step("fz_1", 1,1,0,0,1, 2'b01, 2'b00);
    step("fz_2", 1,1,0,0,1, 2'b01, 2'b00);
    step("fz_3", 1,1,0,0,1, 2'b01, 2'b00);
    idle();
    a.dmem_req = 1; a.dmem_ack = 1;
    step("fz_ack", 0,0,0,1,0, 2'b00, 2'b00);
    idle();
    step("fz_run", 0,0,0,0,0, 2'b00, 2'b00);

    // mem_wait outranks a taken branch
    a.dmem_req = 1;
    a.ex_valid = 1; a.ex_branch_taken = 1;
    step("wait_br", 1,1,0,0,1, 2'b00, 2'b00);
    idle();
    step("wait_br_run", 0,0,0,0,0, 2'b00, 2'b00);

    // long wait saturates the 4-bit counter
    a.dmem_req = 1;
    for (int i = 0; i < 20; i++)
      step($sformatf("sat_%0d", i), 1,1,0,0,1, 2'b00, 2'b00);
    idle();
    step("sat_end", 0,0,0,0,0, 2'b00, 2'b00);

    // reset during the second flush cycle
    a.ex_valid = 1; a.ex_branch_taken = 1;
    step("rst_br", 0,0,1,1,0, 2'b00, 2'b00);
    idle();
    a.dmem_req = 1;
    a.mem_valid = 1; a.mem_wr_en = 1; a.mem_rd = 2;
    a.ex_rs1 = 2; a.ex_rs1_used = 1;
    rst = 1;
    step("rst_mid", 0,0,0,0,0, 2'b00, 2'b00);
    rst = 0;
    idle();
    step("rst_after", 0,0,0,0,0, 2'b00, 2'b00);
    step("rst_after2", 0,0,0,0,0, 2'b00, 2'b00);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(negedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending required 0",
               exp_q.size());
    end
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
